rob_multi: RTL and testbench
============================

ROB_MULTI -- requirements
Module: rob_multi

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entry count; power of two, at least 4.
REQ-002 SHALL have parameter NUM_WB, default 3, number of writeback (CDB) ports.
REQ-003 SHALL have parameter RETIRE_W, default 2, maximum retirements per cycle; 1 to 4.
REQ-004 SHALL have parameter PREG_W, default 7, physical register index width. TAG_W = $clog2(DEPTH).
REQ-005 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-006 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports alloc_valid in 1, alloc_pd_new in PREG_W, alloc_pd_old in PREG_W, alloc_pc in 32: dispatch allocation request and its payload.
REQ-008 SHALL have ports alloc_ready out 1 (entry free) and alloc_tag out TAG_W (tail index the next allocation receives).
REQ-009 SHALL have ports wb_valid in NUM_WB and wb_tag in NUM_WB*TAG_W: completion per port; port i tag in bits [i*TAG_W +: TAG_W].
REQ-010 SHALL have ports br_mispredict in 1 and br_tag in TAG_W: mispredicting branch and its tag.
REQ-011 SHALL have ports retire_valid out RETIRE_W and retire_pd_old out RETIRE_W*PREG_W: slot i is oldest-first.
REQ-012 SHALL have ports flush out 1, flush_tag out TAG_W, count out TAG_W+1, empty out 1.

Function
REQ-013 SHALL keep head and tail pointers TAG_W+1 bits wide, the MSB being a wrap bit; count = tail - head; full when count == DEPTH; empty when count == 0.
REQ-014 SHALL drive alloc_ready = !full from registered state, with no same-cycle bypass from retirement.
REQ-015 SHALL, on alloc_valid && alloc_ready, write {valid=1, done=0, pd_new, pd_old, pc} at tail and advance tail by 1 at the edge.
REQ-016 SHALL, for each wb_valid[i], set done on entry wb_tag[i] at the edge if that entry is valid; SHALL ignore invalid targets; duplicate tags across ports SHALL be harmless.
REQ-017 SHALL drive retire_valid[i] combinationally, asserted iff entries head..head+i are all valid and done; valid bits SHALL always form a contiguous prefix.
REQ-018 SHALL, at the edge, clear valid on retired entries and advance head by the number of asserted retire_valid bits; a done bit set at edge N SHALL first be retireable in cycle N+1.
REQ-019 SHALL, on br_mispredict, invalidate every entry strictly younger than br_tag and set tail = br_tag+1 with the correct wrap bit; the branch entry SHALL remain.
REQ-020 SHALL, in a mispredict cycle, ignore alloc_valid; retirement and writeback of entries at or older than br_tag SHALL still proceed that cycle.
REQ-021 SHALL register flush = br_mispredict and flush_tag = br_tag, so each is a one-cycle pulse one cycle later.
REQ-022 SHALL ignore br_mispredict whose br_tag is not a valid entry.

Reset
REQ-023 SHALL, on reset: head=tail=0, all valid/done=0, flush=0, flush_tag=0, retire_valid=0, count=0, empty=1, alloc_ready=1, alloc_tag=0.
REQ-024 SHALL let reset override all concurrent alloc, writeback and mispredict inputs, including reset asserted mid-flush.

Configuration
REQ-025 SHALL, with ROB_PERF_EN defined, add output perf_retired out 32: count of retired instructions, +popcount(retire_valid) per cycle, reset to 0, wrapping modulo 2^32.
REQ-026 SHALL, without ROB_PERF_EN, omit perf_retired and the counter logic; all other behaviour SHALL be identical.

Verification
REQ-027 SHALL test fill: 16 allocs with pc 0,4,...,60 -> alloc_tag 0..15; after the 16th alloc_ready=0 and count=16; a 17th request is dropped.
REQ-028 SHALL test out-of-order completion: wb tags 3, 1, 0, 2 in separate cycles -> nothing retires until tag 0 is done; then slots retire 0,1 and next cycle 2,3.
REQ-029 SHALL test multi-port writeback: tags 4, 5, 6 on ports 0-2 in one cycle with head=4 -> next cycle retire_valid=2'b11; the following cycle tag 6 retires alone.
REQ-030 SHALL test mispredict: 8 entries allocated (tags 0-7), br_mispredict with br_tag=3 -> next cycle count=4, alloc_tag=4, flush=1 with flush_tag=3 for exactly one cycle; a later wb to tag 5 is ignored.
REQ-031 SHALL test wrap: head=14, tail=14; allocate 4 -> tags 14,15,0,1; complete all -> retirements in order 14,15,0,1 and empty=1.
REQ-032 SHALL test reset mid-flush: reset asserted in the cycle after br_mispredict -> all outputs take reset values at the next edge; with ROB_PERF_EN, perf_retired=0.

Source files
------------

// File: rtl/rob_multi.sv
// rob_multi -- reorder buffer with multi-port writeback and multi-wide retirement.
//
// Entries are allocated in program order at the tail. Each entry is marked done
// by any of NUM_WB writeback ports. Up to RETIRE_W entries retire per cycle from
// the head, oldest first. A mispredicting branch squashes every entry younger
// than itself and rewinds the tail to just past the branch.
//
// Parameters: DEPTH (entries, power of two, >= 4), NUM_WB (writeback ports),
//             RETIRE_W (retire width, 1..4), PREG_W (physical register index width).
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   alloc_valid/pd_new/pd_old/pc   dispatch allocation request + payload
//   alloc_ready, alloc_tag   an entry is free; tag the next allocation receives
//   wb_valid, wb_tag         per-port completion, port i tag at [i*TAG_W +: TAG_W]
//   br_mispredict, br_tag    mispredicting branch and its tag
//   retire_valid, retire_pd_old    retire slots, slot 0 oldest
//   flush, flush_tag         registered one-cycle echo of an accepted mispredict
//   count, empty             occupancy
//   perf_retired             retired-instruction counter (only with ROB_PERF_EN)
//
// Build option: define ROB_PERF_EN to add the perf_retired output and counter.

module rob_multi #(
    parameter int DEPTH    = 16,
    parameter int NUM_WB   = 3,
    parameter int RETIRE_W = 2,
    parameter int PREG_W   = 7,
    localparam int TAG_W   = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alloc_valid,
    input  logic [PREG_W-1:0]          alloc_pd_new,
    input  logic [PREG_W-1:0]          alloc_pd_old,
    input  logic [31:0]                alloc_pc,
    output logic                       alloc_ready,
    output logic [TAG_W-1:0]           alloc_tag,
    input  logic [NUM_WB-1:0]          wb_valid,
    input  logic [NUM_WB*TAG_W-1:0]    wb_tag,
    input  logic                       br_mispredict,
    input  logic [TAG_W-1:0]           br_tag,
    output logic [RETIRE_W-1:0]        retire_valid,
    output logic [RETIRE_W*PREG_W-1:0] retire_pd_old,
    output logic                       flush,
    output logic [TAG_W-1:0]           flush_tag,
    output logic [TAG_W:0]             count,
`ifdef ROB_PERF_EN
    output logic [31:0]                perf_retired,
`endif
    output logic                       empty
);

    localparam int PTR_W = TAG_W + 1;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PTR_W-1:0]  head, tail;
    logic [TAG_W-1:0]  head_idx, tail_idx;
    logic [DEPTH-1:0]  valid_q, done_q;

    logic [PREG_W-1:0] pd_new_mem [DEPTH];
    logic [PREG_W-1:0] pd_old_mem [DEPTH];
    logic [31:0]       pc_mem     [DEPTH];

    logic              full;
    logic              alloc_fire;
    logic              br_take;
    logic [TAG_W-1:0]  br_age;
    logic [DEPTH-1:0]  kill;
    logic [PTR_W-1:0]  retire_cnt;
    logic              run;
    logic [TAG_W-1:0]  slot;

    assign head_idx    = head[TAG_W-1:0];
    assign tail_idx    = tail[TAG_W-1:0];
    assign count       = tail - head;
    assign full        = (count == PTR_W'(DEPTH));
    assign empty       = (count == '0);
    assign alloc_ready = !full;
    assign alloc_tag   = tail_idx;

    // A mispredict is honoured only when it names a live entry.
    assign br_take    = br_mispredict && valid_q[br_tag];
    assign br_age     = br_tag - head_idx;
    assign alloc_fire = alloc_valid && alloc_ready && !br_take;

    // Entries whose distance from head exceeds the branch's are younger than it.
    always_comb begin
        kill = '0;
        for (int k = 0; k < DEPTH; k++) begin
            kill[k] = br_take && ((TAG_W'(k) - head_idx) > br_age);
        end
    end

    // Retire the longest valid+done run from head; during an accepted
    // mispredict the run stops at the branch so squashed work never retires.
    // NOTE: every output of this block is given a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        retire_valid  = '0;
        retire_pd_old = '0;
        retire_cnt    = '0;
        run           = 1'b1;
        slot          = head_idx;
        for (int i = 0; i < RETIRE_W; i++) begin
            slot = head_idx + TAG_W'(i);
            run  = run && valid_q[slot] && done_q[slot]
                       && !(br_take && (TAG_W'(i) > br_age));
            retire_valid[i] = run;
            retire_pd_old[i*PREG_W +: PREG_W] = pd_old_mem[slot];
            if (run) begin
                retire_cnt = retire_cnt + PTR_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every update in
    // this block sees the pre-edge values; later statements win on a conflict.
    always_ff @(posedge clk) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            valid_q   <= '0;
            done_q    <= '0;
            flush     <= 1'b0;
            flush_tag <= '0;
        end else begin
            for (int i = 0; i < NUM_WB; i++) begin
                if (wb_valid[i] && valid_q[wb_tag[i*TAG_W +: TAG_W]]) begin
                    done_q[wb_tag[i*TAG_W +: TAG_W]] <= 1'b1;
                end
            end
            for (int i = 0; i < RETIRE_W; i++) begin
                if (retire_valid[i]) begin
                    valid_q[head_idx + TAG_W'(i)] <= 1'b0;
                    done_q[head_idx + TAG_W'(i)]  <= 1'b0;
                end
            end
            for (int k = 0; k < DEPTH; k++) begin
                if (kill[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
            // The tail slot is never live when alloc_fire, so it cannot
            // collide with the writeback or retire updates above.
            if (alloc_fire) begin
                valid_q[tail_idx] <= 1'b1;
                done_q[tail_idx]  <= 1'b0;
            end

            head <= head + retire_cnt;
            if (br_take) begin
                // Rebuilding from head keeps the wrap bit correct.
                tail <= head + PTR_W'(br_age) + PTR_W'(1);
            end else if (alloc_fire) begin
                tail <= tail + PTR_W'(1);
            end

            flush <= br_take;
            if (br_take) begin
                flush_tag <= br_tag;
            end
        end
    end

    // NOTE: payload storage is not reset; an entry's payload is only observed
    // while its valid bit (which is reset) is set.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            pd_new_mem[tail_idx] <= alloc_pd_new;
            pd_old_mem[tail_idx] <= alloc_pd_old;
            pc_mem[tail_idx]     <= alloc_pc;
        end
    end

    // pd_new and pc are kept per entry for later consumers and debug; nothing
    // on this block's ports reads them yet.
    logic [PREG_W+31:0] unused_head_payload;
    assign unused_head_payload = {pd_new_mem[head_idx], pc_mem[head_idx]};

`ifdef ROB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_retired <= '0;
        end else begin
            perf_retired <= perf_retired + 32'(retire_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_rob_multi.sv
// tb_rob_multi -- self-checking bench for rob_multi (default parameters).
// A program-order queue models the buffer; directed scenarios are followed
// by a randomized phase, all checked against the queue model.

module tb_rob_multi;

    localparam int DEPTH    = 16;
    localparam int NUM_WB   = 3;
    localparam int RETIRE_W = 2;
    localparam int PREG_W   = 7;
    localparam int TAG_W    = 4;

    logic                       clk = 1'b0;
    logic                       reset = 1'b1;
    logic                       alloc_valid;
    logic [PREG_W-1:0]          alloc_pd_new;
    logic [PREG_W-1:0]          alloc_pd_old;
    logic [31:0]                alloc_pc;
    logic                       alloc_ready;
    logic [TAG_W-1:0]           alloc_tag;
    logic [NUM_WB-1:0]          wb_valid;
    logic [NUM_WB*TAG_W-1:0]    wb_tag;
    logic                       br_mispredict;
    logic [TAG_W-1:0]           br_tag;
    logic [RETIRE_W-1:0]        retire_valid;
    logic [RETIRE_W*PREG_W-1:0] retire_pd_old;
    logic                       flush;
    logic [TAG_W-1:0]           flush_tag;
    logic [TAG_W:0]             count;
    logic                       empty;
`ifdef ROB_PERF_EN
    logic [31:0]                perf_retired;
`endif

    always #5 clk = ~clk;

    rob_multi #(
        .DEPTH(DEPTH), .NUM_WB(NUM_WB), .RETIRE_W(RETIRE_W), .PREG_W(PREG_W)
    ) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_pd_new(alloc_pd_new),
        .alloc_pd_old(alloc_pd_old), .alloc_pc(alloc_pc),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag),
        .br_mispredict(br_mispredict), .br_tag(br_tag),
        .retire_valid(retire_valid), .retire_pd_old(retire_pd_old),
        .flush(flush), .flush_tag(flush_tag),
        .count(count),
`ifdef ROB_PERF_EN
        .perf_retired(perf_retired),
`endif
        .empty(empty)
    );

    // Program-order model: element 0 is the oldest live instruction.
    typedef struct {
        logic [PREG_W-1:0] pd_old;
        bit                done;
    } ent_t;

    ent_t        mq[$];
    int          head_seq    = 0;
    bit          flush_m     = 1'b0;
    logic [3:0]  flush_tag_m = '0;
    int unsigned perf_m      = 0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int find_pos(input int t);
        for (int p = 0; p < mq.size(); p++) begin
            if (((head_seq + p) % DEPTH) == t) return p;
        end
        return -1;
    endfunction

    task automatic idle();
        alloc_valid   = 1'b0;
        alloc_pd_new  = '0;
        alloc_pd_old  = '0;
        alloc_pc      = '0;
        wb_valid      = '0;
        wb_tag        = '0;
        br_mispredict = 1'b0;
        br_tag        = '0;
    endtask

    // One clock: drive inputs, compare outputs with the model, take the edge,
    // then advance the model. Returns 1 time unit after the edge, inputs idle.
    task automatic step(input bit av, input logic [6:0] pdo, input logic [2:0] wv,
                        input logic [11:0] wt, input bit br, input logic [3:0] bt);
        int         sz, bpos, n, p, keep;
        logic [1:0]  exp_rv;
        logic [13:0] exp_pd, pd_mask;
        ent_t        e;
        sz = mq.size();
        alloc_valid   = av;
        alloc_pd_old  = pdo;
        alloc_pd_new  = pdo ^ 7'h2a;
        alloc_pc      = 32'((head_seq + sz) * 4);
        wb_valid      = wv;
        wb_tag        = wt;
        br_mispredict = br;
        br_tag        = bt;
        #1;
        bpos = br ? find_pos(int'(bt)) : -1;
        n = 0;
        while (n < RETIRE_W && n < sz && mq[n].done && (bpos < 0 || n <= bpos)) n++;
        exp_rv  = 2'((1 << n) - 1);
        exp_pd  = '0;
        pd_mask = '0;
        for (int i = 0; i < n; i++) begin
            exp_pd[i*7 +: 7]  = mq[i].pd_old;
            pd_mask[i*7 +: 7] = 7'h7f;
        end
        check("count", 32'(count), 32'(sz));
        check("empty", 32'(empty), 32'(sz == 0));
        check("alloc_ready", 32'(alloc_ready), 32'(sz < DEPTH));
        check("alloc_tag", 32'(alloc_tag), 32'((head_seq + sz) % DEPTH));
        check("retire_valid", 32'(retire_valid), 32'(exp_rv));
        check("retire_pd_old", 32'(retire_pd_old & pd_mask), 32'(exp_pd));
        check("flush", 32'(flush), 32'(flush_m));
        if (flush_m) check("flush_tag", 32'(flush_tag), 32'(flush_tag_m));
`ifdef ROB_PERF_EN
        check("perf_retired", perf_retired, perf_m);
`endif
        @(posedge clk);
        for (int k = 0; k < NUM_WB; k++) begin
            if (wv[k]) begin
                p = find_pos(int'(wt[k*4 +: 4]));
                if (p >= 0) begin
                    e = mq[p];
                    e.done = 1'b1;
                    mq[p] = e;
                end
            end
        end
        for (int i = 0; i < n; i++) void'(mq.pop_front());
        head_seq += n;
        if (bpos >= 0) begin
            keep = bpos + 1 - n;
            while (mq.size() > keep) void'(mq.pop_back());
        end else if (av && sz < DEPTH) begin
            mq.push_back('{pd_old: pdo, done: 1'b0});
        end
        perf_m += n;
        flush_m = (bpos >= 0);
        if (bpos >= 0) flush_tag_m = bt;
        #1;
        idle();
    endtask

    // Synchronous reset for one edge, optionally with every other input active.
    task automatic do_reset(input bit junk);
        idle();
        if (junk) begin
            alloc_valid   = 1'b1;
            alloc_pd_old  = 7'h11;
            wb_valid      = '1;
            wb_tag        = 12'h210;
            br_mispredict = 1'b1;
            br_tag        = 4'd1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
        mq.delete();
        head_seq    = 0;
        flush_m     = 1'b0;
        flush_tag_m = '0;
        perf_m      = 0;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        check("rst_alloc_tag", 32'(alloc_tag), 32'd0);
        check("rst_retire_valid", 32'(retire_valid), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_flush_tag", 32'(flush_tag), 32'd0);
`ifdef ROB_PERF_EN
        check("rst_perf_retired", perf_retired, 32'd0);
`endif
    endtask

    bit         r_av, r_br;
    logic [6:0] r_pd;
    logic [2:0] r_wv;
    logic [11:0] r_wt;
    logic [3:0] r_bt;

    initial begin
        idle();
        do_reset(1'b0);

        // Fill: tags 0..15, then full and a dropped 17th request.
        for (int i = 0; i < 16; i++) begin
            check("fill_alloc_tag", 32'(alloc_tag), 32'(i));
            step(1'b1, 7'(i), 3'b000, 12'h0, 1'b0, 4'd0);
        end
        check("full_alloc_ready", 32'(alloc_ready), 32'd0);
        check("full_count", 32'(count), 32'd16);
        step(1'b1, 7'h7f, 3'b000, 12'h0, 1'b0, 4'd0);
        check("drop_count", 32'(count), 32'd16);

        // Out-of-order completion 3, 1, 0, 2.
        step(1'b0, 7'd0, 3'b001, 12'h003, 1'b0, 4'd0);
        check("ooo_hold_a", 32'(retire_valid), 32'd0);
        step(1'b0, 7'd0, 3'b001, 12'h001, 1'b0, 4'd0);
        check("ooo_hold_b", 32'(retire_valid), 32'd0);
        step(1'b0, 7'd0, 3'b001, 12'h000, 1'b0, 4'd0);
        check("ooo_rv_01", 32'(retire_valid), 32'd3);
        check("ooo_pd_01", 32'(retire_pd_old), 32'({7'd1, 7'd0}));
        step(1'b0, 7'd0, 3'b001, 12'h002, 1'b0, 4'd0);
        check("ooo_rv_23", 32'(retire_valid), 32'd3);
        check("ooo_pd_23", 32'(retire_pd_old), 32'({7'd3, 7'd2}));
        step(1'b0, 7'd0, 3'b000, 12'h0, 1'b0, 4'd0);
        check("ooo_count", 32'(count), 32'd12);

        // Three writebacks in one cycle with head at 4.
        step(1'b0, 7'd0, 3'b111, {4'd6, 4'd5, 4'd4}, 1'b0, 4'd0);
        check("mwb_rv_45", 32'(retire_valid), 32'd3);
        step(1'b0, 7'd0, 3'b000, 12'h0, 1'b0, 4'd0);
        check("mwb_rv_6", 32'(retire_valid), 32'd1);
        check("mwb_pd_6", 32'(retire_pd_old[6:0]), 32'd6);
        step(1'b0, 7'd0, 3'b000, 12'h0, 1'b0, 4'd0);
        check("mwb_count", 32'(count), 32'd9);

        // Mispredict at tag 3 of 0..7.
        do_reset(1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 7'(20 + i), 3'b000, 12'h0, 1'b0, 4'd0);
        step(1'b0, 7'd0, 3'b000, 12'h0, 1'b1, 4'd3);
        check("mp_count", 32'(count), 32'd4);
        check("mp_alloc_tag", 32'(alloc_tag), 32'd4);
        check("mp_flush", 32'(flush), 32'd1);
        check("mp_flush_tag", 32'(flush_tag), 32'd3);
        step(1'b0, 7'd0, 3'b010, {4'd0, 4'd5, 4'd0}, 1'b0, 4'd0);
        check("mp_flush_gone", 32'(flush), 32'd0);
        check("mp_wb_dead_count", 32'(count), 32'd4);
        step(1'b1, 7'd30, 3'b000, 12'h0, 1'b0, 4'd0);
        step(1'b1, 7'd31, 3'b000, 12'h0, 1'b0, 4'd0);
        step(1'b0, 7'd0, 3'b111, {4'd2, 4'd1, 4'd0}, 1'b0, 4'd0);
        step(1'b0, 7'd0, 3'b011, {4'd0, 4'd4, 4'd3}, 1'b0, 4'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 7'd0, 3'b000, 12'h0, 1'b0, 4'd0);
        check("mp_tag5_waits", 32'(count), 32'd1);
        check("mp_tag5_rv", 32'(retire_valid), 32'd0);
        // Mispredict naming a dead entry does nothing; alloc still proceeds.
        step(1'b0, 7'd0, 3'b000, 12'h0, 1'b1, 4'd10);
        check("badbr_flush", 32'(flush), 32'd0);
        check("badbr_count", 32'(count), 32'd1);
        step(1'b1, 7'd33, 3'b000, 12'h0, 1'b1, 4'd12);
        check("badbr_alloc", 32'(count), 32'd2);

        // Wrap: head = tail = 14, then tags 14, 15, 0, 1.
        do_reset(1'b0);
        for (int i = 0; i < 14; i++) step(1'b1, 7'(40 + i), 3'b000, 12'h0, 1'b0, 4'd0);
        for (int b = 0; b < 14; b += 3)
            step(1'b0, 7'd0, 3'b111, {4'(b + 2), 4'(b + 1), 4'(b)}, 1'b0, 4'd0);
        for (int i = 0; i < 8; i++) step(1'b0, 7'd0, 3'b000, 12'h0, 1'b0, 4'd0);
        check("wrap_empty0", 32'(empty), 32'd1);
        check("wrap_start_tag", 32'(alloc_tag), 32'd14);
        for (int j = 0; j < 4; j++) begin
            check("wrap_alloc_tag", 32'(alloc_tag), 32'((14 + j) % 16));
            step(1'b1, 7'(100 + j), 3'b000, 12'h0, 1'b0, 4'd0);
        end
        step(1'b0, 7'd0, 3'b111, {4'd0, 4'd15, 4'd14}, 1'b0, 4'd0);
        check("wrap_rv_a", 32'(retire_valid), 32'd3);
        check("wrap_pd_a", 32'(retire_pd_old), 32'({7'd101, 7'd100}));
        step(1'b0, 7'd0, 3'b001, 12'h001, 1'b0, 4'd0);
        check("wrap_rv_b", 32'(retire_valid), 32'd3);
        check("wrap_pd_b", 32'(retire_pd_old), 32'({7'd103, 7'd102}));
        step(1'b0, 7'd0, 3'b000, 12'h0, 1'b0, 4'd0);
        check("wrap_empty1", 32'(empty), 32'd1);

        // Reset in the cycle after a mispredict, with all inputs active.
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 7'(60 + i), 3'b000, 12'h0, 1'b0, 4'd0);
        step(1'b0, 7'd0, 3'b000, 12'h0, 1'b1, 4'd2);
        check("midflush_flush", 32'(flush), 32'd1);
        do_reset(1'b1);

        // Randomized traffic against the model.
        for (int c = 0; c < 800; c++) begin
            r_av = ($urandom_range(0, 9) < 7);
            r_pd = 7'($urandom);
            r_wv = 3'($urandom);
            for (int k = 0; k < NUM_WB; k++) begin
                if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                    r_wt[k*4 +: 4] = 4'((head_seq + int'($urandom_range(0, mq.size() - 1))) % DEPTH);
                else
                    r_wt[k*4 +: 4] = 4'($urandom);
            end
            r_br = ($urandom_range(0, 15) == 0);
            if (mq.size() > 0 && $urandom_range(0, 4) != 0)
                r_bt = 4'((head_seq + int'($urandom_range(0, mq.size() - 1))) % DEPTH);
            else
                r_bt = 4'($urandom);
            step(r_av, r_pd, r_wv, r_wt, r_br, r_bt);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
